// File: rtl/axis2avst_pkg.sv
// Shared definitions for the AXI4-Stream <-> Avalon-ST adapters.
// keep2empty is also used by the receive-side adapter's checks.
package axis2avst_pkg;

  localparam int unsigned MAX_READY_LATENCY = 8;
  localparam int unsigned MAX_KEEP_WIDTH    = 128;

  typedef enum logic {
    FRM_IDLE = 1'b0,
    FRM_BODY = 1'b1
  } frame_state_t;

  // Count of zero lanes above the highest set keep bit, saturated at keep_width-1.
  function automatic int unsigned keep2empty(
    input logic [MAX_KEEP_WIDTH-1:0] keep,
    input int unsigned               keep_width
  );
    int unsigned top;
    top = 0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      if (i < keep_width && keep[i]) begin
        top = i + 1;
      end
    end
    if (top == 0) begin
      return keep_width - 1;
    end
    return keep_width - top;
  endfunction

endpackage

// File: rtl/axis2avst_fifo.sv
// Output FIFO for axis2avst: registered full_n/empty_n, no bypass.
// Only pointers and occupancy are reset; storage is left uninitialised.
module axis2avst_fifo
  import axis2avst_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full_n,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty_n
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full_n;
  logic             r_empty_n;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_push      = i_wr_en && r_full_n;
    w_pop       = i_rd_en && r_empty_n;
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Flags are computed from post-push/pop occupancy so they are valid next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full_n  <= 1'b0;
      r_empty_n <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      r_full_n  <= (w_count_nxt < CW'(DEPTH));
      r_empty_n <= (w_count_nxt != '0);
    end
  end

  assign o_full_n  = r_full_n;
  assign o_empty_n = r_empty_n;
  assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/axis2avst.sv
// AXI4-Stream to Avalon-ST source adapter with configurable ready latency.
// Derives SOP from frame tracking and converts tkeep to empty on the EOP beat.
module axis2avst
  import axis2avst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter bit          KEEP_ENABLE   = (DATA_WIDTH > 8),
  parameter int unsigned EMPTY_WIDTH   = $clog2(KEEP_WIDTH),
  parameter bit          BYTE_REVERSE  = 1'b0,
  parameter int unsigned READY_LATENCY = 0,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  axis_tkeep,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic                   axis_tlast,
  input  logic                   axis_tuser,
  input  logic                   avst_ready,
  output logic                   avst_valid,
  output logic [DATA_WIDTH-1:0]  avst_data,
  output logic                   avst_startofpacket,
  output logic                   avst_endofpacket,
  output logic [EMPTY_WIDTH-1:0] avst_empty,
  output logic                   avst_error
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + EMPTY_WIDTH + 3;
  localparam int unsigned HIST_W  = (READY_LATENCY > 0) ? READY_LATENCY : 1;

  frame_state_t               r_frame;
  logic [HIST_W-1:0]          r_rdy_hist;
  logic                       w_accept;
  logic                       w_sop;
  logic                       w_error;
  logic [EMPTY_WIDTH-1:0]     w_empty;
  logic [DATA_WIDTH-1:0]      w_data;
  logic [MAX_KEEP_WIDTH-1:0]  w_keep_ext;
  logic [ENTRY_W-1:0]         w_wr_entry;
  logic [ENTRY_W-1:0]         w_rd_entry;
  logic                       w_full_n;
  logic                       w_empty_n;
  logic                       w_grant;
  logic                       w_valid;
  logic                       w_pop;

  assign axis_tready = w_full_n;
  assign w_accept    = axis_tvalid && w_full_n;
  assign w_sop       = (r_frame == FRM_IDLE);

  always_comb begin
    w_data = axis_tdata;
    if (BYTE_REVERSE) begin
      for (int unsigned n = 0; n < KEEP_WIDTH; n++) begin
        w_data[n*8 +: 8] = axis_tdata[(KEEP_WIDTH-1-n)*8 +: 8];
      end
    end
  end

  // Only the MSB-side keep boundary matters; holes in tkeep are not checked.
  always_comb begin
    w_keep_ext                 = '0;
    w_keep_ext[KEEP_WIDTH-1:0] = axis_tkeep;
    w_empty                    = '0;
    if (KEEP_ENABLE && axis_tlast) begin
      w_empty = EMPTY_WIDTH'(keep2empty(w_keep_ext, KEEP_WIDTH));
    end
    w_error = axis_tuser | (axis_tlast & KEEP_ENABLE & (axis_tkeep == '0));
  end

  assign w_wr_entry = {w_error, w_empty, axis_tlast, w_sop, w_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= FRM_IDLE;
    end else if (w_accept) begin
      r_frame <= axis_tlast ? FRM_IDLE : FRM_BODY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_hist <= '0;
    end else begin
      r_rdy_hist <= (r_rdy_hist << 1) | HIST_W'(avst_ready);
    end
  end

  // With latency > 0 a granted valid is a transfer by definition, so pop ignores avst_ready.
  always_comb begin
    w_grant = (READY_LATENCY == 0) ? 1'b1 : r_rdy_hist[HIST_W-1];
    w_valid = w_grant && w_empty_n;
    w_pop   = w_valid && ((READY_LATENCY == 0) ? avst_ready : 1'b1);
  end

  axis2avst_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_data (w_wr_entry),
    .o_full_n  (w_full_n),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_entry),
    .o_empty_n (w_empty_n)
  );

  always_comb begin
    avst_valid = w_valid;
    {avst_error, avst_empty, avst_endofpacket, avst_startofpacket, avst_data} = '0;
    if (w_empty_n) begin
      {avst_error, avst_empty, avst_endofpacket, avst_startofpacket, avst_data} = w_rd_entry;
    end
  end

endmodule

// File: tb/tb_axis2avst.sv
// Bench for axis2avst: instance 0 default (latency 0), instance 1 latency 3 / depth 8 / byte reverse.
module tb_axis2avst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] tdata  [2];
  logic [7:0]  tkeep  [2];
  logic        tvalid [2];
  logic        tlast  [2];
  logic        tuser  [2];
  logic        tready [2];
  logic        aready [2];
  logic        avalid [2];
  logic [63:0] adata  [2];
  logic        asop   [2];
  logic        aeop   [2];
  logic [2:0]  aempty [2];
  logic        aerr   [2];

  axis2avst u0 (
    .clk(clk), .rst_n(rst_n),
    .axis_tdata(tdata[0]), .axis_tkeep(tkeep[0]), .axis_tvalid(tvalid[0]),
    .axis_tready(tready[0]), .axis_tlast(tlast[0]), .axis_tuser(tuser[0]),
    .avst_ready(aready[0]), .avst_valid(avalid[0]), .avst_data(adata[0]),
    .avst_startofpacket(asop[0]), .avst_endofpacket(aeop[0]),
    .avst_empty(aempty[0]), .avst_error(aerr[0])
  );

  axis2avst #(
    .READY_LATENCY (3),
    .FIFO_DEPTH    (8),
    .BYTE_REVERSE  (1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .axis_tdata(tdata[1]), .axis_tkeep(tkeep[1]), .axis_tvalid(tvalid[1]),
    .axis_tready(tready[1]), .axis_tlast(tlast[1]), .axis_tuser(tuser[1]),
    .avst_ready(aready[1]), .avst_valid(avalid[1]), .avst_data(adata[1]),
    .avst_startofpacket(asop[1]), .avst_endofpacket(aeop[1]),
    .avst_empty(aempty[1]), .avst_error(aerr[1])
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        err;
  } beat_t;

  beat_t mq   [2][1024];
  int    mhead[2];
  int    mtail[2];
  logic  min_frame[2];
  logic  hist [2][8];
  logic  post_rst[2];
  beat_t logb [2][256];
  int    lcnt [2];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit tp_on    = 1'b0;
  int tp_first_acc, tp_first_out, tp_last_out, tp_outs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_empty(input logic [7:0] k);
    int z;
    z = 0;
    while (z < 8 && !k[7-z]) z++;
    return (z > 7) ? 3'd7 : 3'(z);
  endfunction

  function automatic logic [63:0] m_rev(input logic [63:0] d);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = d[8*(7-b) +: 8];
    return r;
  endfunction

  // Reference model and per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int    depth, lat, n;
      logic  expr, expv, xfer;
      beat_t e, b;
      depth = (i == 0) ? 4 : 8;
      lat   = (i == 0) ? 0 : 3;
      if (!rst_n) begin
        chk($sformatf("reset_ctl%0d", i),
            {56'd0, tready[i], avalid[i], asop[i], aeop[i], aerr[i], aempty[i]}, 64'd0);
        chk($sformatf("reset_data%0d", i), adata[i], 64'd0);
        mhead[i] = 0; mtail[i] = 0; min_frame[i] = 1'b0; post_rst[i] = 1'b1;
        for (int k = 0; k < 8; k++) hist[i][k] = 1'b0;
      end else begin
        n    = mtail[i] - mhead[i];
        expr = !post_rst[i] && (n < depth);
        chk($sformatf("tready%0d", i), tready[i], expr);
        expv = ((lat == 0) ? 1'b1 : hist[i][lat-1]) && (n > 0);
        chk($sformatf("valid%0d", i), avalid[i], expv);
        if (n > 0) e = mq[i][mhead[i]];
        else begin
          e.data = '0; e.sop = 1'b0; e.eop = 1'b0; e.empty = '0; e.err = 1'b0;
        end
        chk($sformatf("data%0d", i),  adata[i],  e.data);
        chk($sformatf("sop%0d", i),   asop[i],   e.sop);
        chk($sformatf("eop%0d", i),   aeop[i],   e.eop);
        chk($sformatf("empty%0d", i), aempty[i], e.empty);
        chk($sformatf("error%0d", i), aerr[i],   e.err);
        xfer = expv && (lat != 0 || aready[i]);
        if (xfer) begin
          if (lcnt[i] < 256) logb[i][lcnt[i]] = e;
          lcnt[i]++;
          mhead[i]++;
          if (i == 0 && tp_on) begin
            tp_outs++;
            if (tp_first_out < 0) tp_first_out = cyc;
            tp_last_out = cyc;
          end
        end
        if (tvalid[i] && expr) begin
          b.data  = (i == 1) ? m_rev(tdata[i]) : tdata[i];
          b.sop   = !min_frame[i];
          b.eop   = tlast[i];
          b.empty = tlast[i] ? m_empty(tkeep[i]) : 3'd0;
          b.err   = tuser[i] | (tlast[i] & (tkeep[i] == 8'h00));
          if (mtail[i] < 1024) mq[i][mtail[i]] = b;
          mtail[i]++;
          min_frame[i] = !tlast[i];
          if (i == 0 && tp_on && tp_first_acc < 0) tp_first_acc = cyc;
        end
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0]  = aready[i];
        post_rst[i] = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u);
    bit ok;
    ok = 1'b0;
    tvalid[i] = 1'b1; tdata[i] = d; tkeep[i] = k; tlast[i] = l; tuser[i] = u;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = tready[i];
      @(posedge clk);
      #1;
    end
    tvalid[i] = 1'b0;
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout%0d: got no accept, required accept within 300 cycles", i);
    end
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 300 && mtail[i] != mhead[i]; t++) idle(1);
    if (mtail[i] != mhead[i]) begin
      n_checks++; n_err++;
      $display("FAIL drain_timeout%0d: got %0d beats left, required 0", i, mtail[i] - mhead[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int          base;
    int          base1;
    logic [2:0]  exp_e [3];
    logic        exp_s [3];
    logic        exp_p [3];
    logic        exp_r [3];
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tdata[i] = '0; tkeep[i] = '0; tvalid[i] = 1'b0; tlast[i] = 1'b0;
      tuser[i] = 1'b0; aready[i] = 1'b1; lcnt[i] = 0;
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single-beat frame
    base = lcnt[0];
    send(0, 64'h1122334455667788, 8'h0F, 1'b1, 1'b0);
    drain(0);
    chk("single_count", 64'(lcnt[0] - base), 64'd1);
    chk("single_sop",   logb[0][base].sop,   1'b1);
    chk("single_eop",   logb[0][base].eop,   1'b1);
    chk("single_empty", logb[0][base].empty, 3'd4);
    chk("single_err",   logb[0][base].err,   1'b0);
    chk("single_data",  logb[0][base].data,  64'h1122334455667788);

    // 3-beat frame, last tkeep 7F
    base = lcnt[0];
    send(0, 64'hA0A0A0A0A0A0A0A0, 8'hFF, 1'b0, 1'b0);
    send(0, 64'hB1B1B1B1B1B1B1B1, 8'hFF, 1'b0, 1'b0);
    send(0, 64'h00C2C3C4C5C6C7C8, 8'h7F, 1'b1, 1'b0);
    drain(0);
    exp_e = '{3'd0, 3'd0, 3'd1};
    exp_s = '{1'b1, 1'b0, 1'b0};
    exp_p = '{1'b0, 1'b0, 1'b1};
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("f3_empty%0d", j), logb[0][base+j].empty, exp_e[j]);
      chk($sformatf("f3_sop%0d", j),   logb[0][base+j].sop,   exp_s[j]);
      chk($sformatf("f3_eop%0d", j),   logb[0][base+j].eop,   exp_p[j]);
    end
    chk("f3_data2", logb[0][base+2].data, 64'h00C2C3C4C5C6C7C8);

    // Byte-reversed 3-beat frame on the latency-3 instance
    base1 = lcnt[1];
    send(1, 64'h0011223344556677, 8'hFF, 1'b0, 1'b0);
    send(1, 64'h8899AABBCCDDEEFF, 8'hFF, 1'b0, 1'b0);
    send(1, 64'h0102030405060708, 8'h7F, 1'b1, 1'b0);
    drain(1);
    chk("rev_data0",  logb[1][base1].data,    64'h7766554433221100);
    chk("rev_data1",  logb[1][base1+1].data,  64'hFFEEDDCCBBAA9988);
    chk("rev_empty2", logb[1][base1+2].empty, 3'd1);

    // Error handling
    base = lcnt[0];
    send(0, 64'h1111111111111111, 8'hFF, 1'b0, 1'b0);
    send(0, 64'h2222222222222222, 8'hFF, 1'b0, 1'b1);
    send(0, 64'h3333333333333333, 8'hFF, 1'b1, 1'b0);
    send(0, 64'h4444444444444444, 8'h00, 1'b1, 1'b0);
    drain(0);
    exp_r = '{1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 3; j++)
      chk($sformatf("tuser_err%0d", j), logb[0][base+j].err, exp_r[j]);
    chk("keep0_empty", logb[0][base+3].empty, 3'd7);
    chk("keep0_err",   logb[0][base+3].err,   1'b1);
    chk("keep0_sop",   logb[0][base+3].sop,   1'b1);

    // Backpressure: ready 5 on / 4 off, latency 3, depth 8
    base1 = lcnt[1];
    fork
      begin
        for (int b = 0; b < 20; b++)
          send(1, {32'hB0B00000 | 32'(b), 32'(b * 3)}, (b % 5 == 4) ? 8'h3F : 8'hFF,
               (b % 5 == 4), 1'b0);
      end
      begin
        for (int c = 0; c < 120; c++) begin
          aready[1] = ((c % 9) < 5);
          idle(1);
        end
      end
    join
    aready[1] = 1'b1;
    drain(1);
    chk("bp_count", 64'(lcnt[1] - base1), 64'd20);

    // Reset mid-frame with two beats parked in the FIFO
    aready[0] = 1'b0;
    send(0, 64'hDEAD000000000001, 8'hFF, 1'b0, 1'b0);
    send(0, 64'hDEAD000000000002, 8'hFF, 1'b0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    aready[0] = 1'b1;
    idle(3);
    base = lcnt[0];
    send(0, 64'hBEEF000000000003, 8'hFF, 1'b0, 1'b0);
    send(0, 64'hBEEF000000000004, 8'h03, 1'b1, 1'b0);
    drain(0);
    chk("rst_count", 64'(lcnt[0] - base), 64'd2);
    chk("rst_sop0",  logb[0][base].sop,   1'b1);
    chk("rst_sop1",  logb[0][base+1].sop, 1'b0);
    chk("rst_data0", logb[0][base].data,  64'hBEEF000000000003);
    chk("rst_empty", logb[0][base+1].empty, 3'd6);

    // Throughput: 64 back-to-back beats
    tp_first_acc = -1; tp_first_out = -1; tp_last_out = -1; tp_outs = 0;
    tp_on = 1'b1;
    for (int b = 0; b < 64; b++)
      send(0, 64'h0123000000000000 | 64'(b), 8'hFF, (b == 63), 1'b0);
    drain(0);
    tp_on = 1'b0;
    chk("tp_outs",    64'(tp_outs), 64'd64);
    chk("tp_latency", 64'(tp_first_out - tp_first_acc), 64'd1);
    chk("tp_span",    64'(tp_last_out - tp_first_acc), 64'd64);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/axis2avst.md
# axis2avst

Converts an AXI4-Stream source into an Avalon-ST source with configurable ready latency. It is the transmit-direction counterpart of the Avalon-to-AXI adapter and sits between the MAC/FIFO AXI-stream fabric and Intel hard-IP Avalon-ST sinks (e.g. the E-tile MAC TX). The block generates `startofpacket` from frame tracking and converts `tkeep` to `empty`. A small output FIFO absorbs beats that are still in flight when the sink deasserts `ready` under `READY_LATENCY > 0`.

## Interface
- `DATA_WIDTH`, 64: data bus width in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: number of byte lanes.
- `KEEP_ENABLE`, `DATA_WIDTH>8`: 1 = use `tkeep`; 0 = `empty` tied to 0.
- `EMPTY_WIDTH`, `$clog2(KEEP_WIDTH)`: width of `avst_empty`.
- `BYTE_REVERSE`, 0: 1 = lane n of `tdata` drives lane `KEEP_WIDTH-1-n` of `avst_data`.
- `READY_LATENCY`, 0: Avalon-ST ready latency. Legal range 0..8.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of 2 and ≥ `READY_LATENCY+2`.
- Ports:
  - `clk` in, 1: sole clock.
  - `rst_n` in, 1: asynchronous active-low reset.
  - `axis_tdata` in, `DATA_WIDTH`
  - `axis_tkeep` in, `KEEP_WIDTH`
  - `axis_tvalid` in, 1
  - `axis_tready` out, 1
  - `axis_tlast` in, 1
  - `axis_tuser` in, 1: bad-frame flag.
  - `avst_ready` in, 1
  - `avst_valid` out, 1
  - `avst_data` out, `DATA_WIDTH`
  - `avst_startofpacket` out, 1
  - `avst_endofpacket` out, 1
  - `avst_empty` out, `EMPTY_WIDTH`
  - `avst_error` out, 1

## Operation
- **Input accept.** A beat is accepted when `axis_tvalid && axis_tready`.
  - `axis_tready` is registered and equals `count < FIFO_DEPTH` after the current cycle's push/pop.
  - There is no combinational path from `avst_ready` to `axis_tready`.
- **Frame tracking.** `in_frame` is set on an accepted beat with `tlast=0` and cleared on an accepted beat with `tlast=1`.
  - Stored SOP bit = `!in_frame` at accept time. A single-beat frame therefore carries SOP=1 and EOP=1.
- **Stored EOP** = `tlast`.
- **Stored empty.**
  - On an EOP beat: the number of zero bits above the highest set bit of `tkeep`, saturated at `KEEP_WIDTH-1`.
  - On a non-EOP beat: 0.
  - If `KEEP_ENABLE=0`: always 0.
- **Stored error** = `tuser | (tlast & KEEP_ENABLE & (tkeep==0))`.
- **Non-contiguous `tkeep`.** Only the MSB-side boundary is used; holes are not checked.
- **Output, `READY_LATENCY=0`.**
  - `avst_valid = !empty`, independent of `avst_ready`.
  - Pop when `avst_valid && avst_ready`.
- **Output, `READY_LATENCY=L≥1`.**
  - A shift register `rdy_hist[L-1:0]` records `avst_ready`.
  - `avst_valid = rdy_hist[L-1] && !empty`. Every asserted valid is a transfer and pops.
  - `avst_valid` is never asserted in a cycle not granted by ready L cycles earlier.
- **Idle outputs.** Data and sideband outputs show the FIFO head whenever it exists. When the FIFO is empty, `avst_valid=0` and all other outputs are don't-care, driven as 0.
- **Reset.**
  - Asserting `rst_n` low, including mid-frame, clears the FIFO, `count`, `in_frame` and `rdy_hist`.
  - Outputs go to 0: `axis_tready=0`, `avst_valid=0`, SOP/EOP/error/empty/data = 0.
  - `axis_tready` rises on the first clock after deassertion.
  - A frame cut by reset is not terminated. The downstream sink must tolerate a SOP without a prior EOP.

## Timing
- Latency: a beat accepted at edge t is presentable on `avst_*` in cycle t+1. With `READY_LATENCY=0` and `avst_ready=1` it transfers in that cycle.
- Sustained throughput is 1 beat/cycle when `avst_ready` stays high.
- Simultaneous push and pop with the FIFO full: the pop frees an entry, but `axis_tready` was already 0 and rises the next cycle.
- Simultaneous push and pop with the FIFO empty is impossible. The FIFO has no bypass, so the minimum latency is 1.
- Sizing: when `avst_ready` falls, up to L further grant cycles and L+1 buffered beats may remain. `FIFO_DEPTH ≥ L+2` guarantees no overflow.
- Overflow/underflow:
  - A push while full cannot occur because `axis_tready=0`.
  - A pop while empty is suppressed because valid=0.
  - Pointers wrap modulo `FIFO_DEPTH`.

## Structure
- Top `axis2avst`: frame tracker, keep→empty encoder, ready-history shifter, byte reverse on the input side.
- Sub-module `axis2avst_fifo`: synchronous FIFO with registered `full_n`.
  - Entry = `{error, empty, eop, sop, data}` (`DATA_WIDTH + EMPTY_WIDTH + 3` bits).
  - Async active-low reset on pointers and count only; the storage array is not reset.
- Shared header/package: the `keep2empty` function and the `MAX_READY_LATENCY=8` constant, reused by the receive-side adapter's checks.

## Test plan
All scenarios use `DATA_WIDTH=64`, `KEEP_WIDTH=8`, `READY_LATENCY=0` unless stated.

- **Single-beat frame.** Input `tkeep=8'h0F`, `tlast=1` → one output beat with SOP=1, EOP=1, `empty=4`, `error=0`.
- **3-beat frame, last beat `tkeep=8'h7F`.** → SOP only on beat 0, EOP only on beat 2. `empty` = 0, 0, 1. Data matches input, and matches byte-reversed when `BYTE_REVERSE=1`.
- **Backpressure, `READY_LATENCY=3`, `FIFO_DEPTH=8`.**
  - Stimulus: stream 20 beats, toggle `avst_ready` in a 5-on/4-off pattern.
  - Required: `avst_valid` only in cycles with ready high 3 cycles earlier, no beat lost or duplicated, `axis_tready` never high while `count==8`.
- **Error handling.**
  - `tuser=1` on the middle beat → `avst_error=1` on that beat only.
  - Last beat with `tkeep=0` → `empty=7`, `error=1`.
- **Reset mid-frame.** Reset after beat 2 of 4 → all outputs 0 during reset. The next frame starts with SOP=1, and the FIFO is empty (`avst_valid=0` until a new accept).
- **Throughput.** 64 back-to-back beats with ready held high → 64 output beats in 65 cycles, first output 1 cycle after the first accept.
